// File: rtl/seq_pattern_tx_if.sv
// Handshake bundle between a pattern requester and seq_pattern_tx.
// The requester drives start/rep_cnt/abort; the transmitter drives the serial stream and status.
interface seq_pattern_tx_if #(
   parameter int CNT_W = 4
);
   logic             start;
   logic [CNT_W-1:0] rep_cnt;
   logic             abort;
   logic             X;
   logic             valid;
   logic             last;
   logic             busy;
   logic             done;

   modport master (
      output start, rep_cnt, abort,
      input  X, valid, last, busy, done
   );

   modport slave (
      input  start, rep_cnt, abort,
      output X, valid, last, busy, done
   );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first rep_cnt times with GAP idle bits between frames.
// Optional build macro SEQ_PATTERN_TX_PARITY_EN appends an even-parity bit to every frame.
//
//   state  | meaning
//   S_IDLE | waiting for start, all outputs low
//   S_SEND | driving frame bit idx onto X
//   S_GAP  | idle zero bits between frames, still busy
//   S_DONE | one-cycle done pulse
module seq_pattern_tx #(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] PATTERN = 3'b101,
   parameter int               GAP     = 2,
   parameter int               CNT_W   = 4
) (
   input logic             clk,
   input logic             rst,
   seq_pattern_tx_if.slave bus
);

`ifdef SEQ_PATTERN_TX_PARITY_EN
   localparam int                 FRAME_W = PAT_W + 1;
   localparam logic [FRAME_W-1:0] FRAME   = {PATTERN, ^PATTERN};
`else
   localparam int                 FRAME_W = PAT_W;
   localparam logic [FRAME_W-1:0] FRAME   = PATTERN;
`endif

   localparam int               IDX_W   = $clog2(FRAME_W);
   localparam int               GAP_W   = 4;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(FRAME_W - 1);
   localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] reps_q, reps_d;
   logic [GAP_W-1:0] gcnt_q, gcnt_d;
   logic             x_q, x_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      reps_d  = reps_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.rep_cnt != '0) begin
                  state_d = S_SEND;
                  idx_d   = IDX_TOP;
                  reps_d  = bus.rep_cnt;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_SEND: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (idx_q == '0) begin
               if (reps_q == CNT_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  reps_d = reps_q - CNT_W'(1);
                  idx_d  = IDX_TOP;
                  // With no gap the next frame starts back-to-back.
                  if (GAP > 0) begin
                     state_d = S_GAP;
                     gcnt_d  = GAP_TOP;
                  end
               end
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         S_GAP: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (gcnt_q == '0) begin
               state_d = S_SEND;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      x_d     = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_d)
         S_SEND: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            last_d  = (idx_d == '0);
            for (int i = 0; i < FRAME_W; i++) begin
               if (idx_d == IDX_W'(i)) x_d = FRAME[i];
            end
         end
         S_GAP:  busy_d = 1'b1;
         S_DONE: done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         reps_q  <= '0;
         gcnt_q  <= '0;
         x_q     <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         reps_q  <= reps_d;
         gcnt_q  <= gcnt_d;
         x_q     <= x_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.X     = x_q;
   assign bus.valid = valid_q;
   assign bus.last  = last_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx (default build: PATTERN=101, GAP=2).
// Expected vectors are {X, valid, last, busy, done} for the cycle each step covers.
module tb_seq_pattern_tx;

   typedef struct {
      logic [4:0] e;
      string      name;
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   int   checks;
   int   fails;
   bit   mon_en;

   seq_pattern_tx_if #(.CNT_W(4)) bus ();

   seq_pattern_tx #(
      .PAT_W  (3),
      .PATTERN(3'b101),
      .GAP    (2),
      .CNT_W  (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives inputs sampled at the coming edge and queues the outputs due in this cycle.
   task automatic step(input logic st, input logic [3:0] rc, input logic ab,
                       input logic rs, input logic [4:0] e, input string name);
      exp_t x;
      @(posedge clk);
      #1;
      bus.start   = st;
      bus.rep_cnt = rc;
      bus.abort   = ab;
      rst         = rs;
      x.e         = e;
      x.name      = name;
      exp_q.push_back(x);
      mon_en      = 1'b1;
   endtask

   always @(negedge clk) begin
      logic [4:0] act;
      exp_t       x;
      act = {bus.X, bus.valid, bus.last, bus.busy, bus.done};
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (act !== x.e) begin
            fails++;
            $display("FAIL %s @%0t: got X/valid/last/busy/done=%b expected %b", x.name, $time, act, x.e);
         end
      end else if (mon_en && act !== 5'b0) begin
         checks++;
         fails++;
         $display("FAIL unexpected_output @%0t: got %b expected 00000", $time, act);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "timeout");
   end

   logic [4:0] rep3 [14];

   initial begin
      checks      = 0;
      fails       = 0;
      mon_en      = 1'b0;
      rst         = 1'b0;
      bus.start   = 1'b1;
      bus.rep_cnt = 4'd1;
      bus.abort   = 1'b0;
      rep3 = '{5'b11010, 5'b01010, 5'b11110, 5'b00010, 5'b00010,
               5'b11010, 5'b01010, 5'b11110, 5'b00010, 5'b00010,
               5'b11010, 5'b01010, 5'b11110, 5'b00001};

      // reset held with start high
      step(1, 1, 0, 0, 5'b00000, "reset");
      step(1, 1, 0, 0, 5'b00000, "reset");
      step(0, 0, 0, 1, 5'b00000, "reset");
      step(0, 0, 0, 1, 5'b00000, "reset_idle");

      // single frame, start re-pulsed mid-frame
      step(1, 1, 0, 1, 5'b00000, "single");
      step(0, 0, 0, 1, 5'b11010, "single");
      step(1, 1, 0, 1, 5'b01010, "single_ign_start");
      step(0, 0, 0, 1, 5'b11110, "single");
      step(0, 0, 0, 1, 5'b00001, "single_done");
      step(0, 0, 0, 1, 5'b00000, "single_idle");

      // start+abort together (start wins), held start relaunches after done
      step(1, 1, 1, 1, 5'b00000, "startwins");
      step(1, 1, 0, 1, 5'b11010, "startwins");
      step(1, 1, 0, 1, 5'b01010, "startwins");
      step(1, 1, 0, 1, 5'b11110, "startwins");
      step(1, 1, 1, 1, 5'b00001, "held_done");
      step(1, 1, 0, 1, 5'b00000, "held_idle");
      step(0, 0, 0, 1, 5'b11010, "relaunch");
      step(0, 0, 0, 1, 5'b01010, "relaunch");
      step(0, 0, 0, 1, 5'b11110, "relaunch");
      step(0, 0, 0, 1, 5'b00001, "relaunch_done");
      step(0, 0, 0, 1, 5'b00000, "relaunch_idle");

      // three repeats with gap; rep_cnt changed after acceptance
      step(1, 3, 0, 1, 5'b00000, "rep3");
      for (int i = 0; i < 14; i++) step(0, 0, 0, 1, rep3[i], "rep3");
      step(0, 0, 0, 1, 5'b00000, "rep3_idle");

      // zero repeat count
      step(1, 0, 0, 1, 5'b00000, "zero");
      step(0, 0, 0, 1, 5'b00001, "zero_done");
      step(0, 0, 0, 1, 5'b00000, "zero_idle");

      // abort in second frame
      step(1, 3, 0, 1, 5'b00000, "abort");
      for (int i = 0; i < 6; i++) step(0, 0, (i == 5), 1, rep3[i], "abort");
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 5'b00000, "abort_quiet");

      // reset in second frame
      step(1, 3, 0, 1, 5'b00000, "midrst");
      for (int i = 0; i < 6; i++) step(0, 0, 0, (i != 5), rep3[i], "midrst");
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 5'b00000, "midrst_quiet");

      // abort during gap
      step(1, 2, 0, 1, 5'b00000, "abortgap");
      step(0, 0, 0, 1, 5'b11010, "abortgap");
      step(0, 0, 0, 1, 5'b01010, "abortgap");
      step(0, 0, 0, 1, 5'b11110, "abortgap");
      step(0, 0, 1, 1, 5'b00010, "abortgap");
      step(0, 0, 0, 1, 5'b00000, "abortgap_quiet");
      step(0, 0, 0, 1, 5'b00000, "abortgap_quiet");

      // maximum repeat count
      step(1, 15, 0, 1, 5'b00000, "max");
      for (int r = 0; r < 15; r++) begin
         step(0, 0, 0, 1, 5'b11010, "max");
         step(0, 0, 0, 1, 5'b01010, "max");
         step(0, 0, 0, 1, 5'b11110, "max_last");
         if (r < 14) begin
            step(0, 0, 0, 1, 5'b00010, "max_gap");
            step(0, 0, 0, 1, 5'b00010, "max_gap");
         end
      end
      step(0, 0, 0, 1, 5'b00001, "max_done");
      step(0, 0, 0, 1, 5'b00000, "max_idle");
      step(0, 0, 0, 1, 5'b00000, "max_idle");

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the generator end of the serial bit-pattern protocol that the team's sequence detectors consume.
- On a start request it drives a fixed PAT_W-bit pattern MSB-first onto X, once per clock.
- The pattern repeats rep_cnt times, with GAP idle zero bits between repeats.
- It then pulses done. Used as the stimulus source and loopback partner for the detector blocks.

Parameters:
- PAT_W, 3, pattern length in bits (legal: 2..16)
- PATTERN, 3'b101, pattern value, sent bit PAT_W-1 first
- GAP, 2, idle zero cycles between repeats (legal: 0..15)
- CNT_W, 4, width of the repeat count

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low: rst=0 at a rising edge resets the block
- start  input  1  request a transmission; sampled only in IDLE
- rep_cnt  input  CNT_W  number of pattern repeats, latched when start is accepted
- abort  input  1  terminate the transmission in progress
- X  output  1  serial data bit
- valid  output  1  X carries a pattern bit this cycle
- last  output  1  X is the final bit of one pattern frame
- busy  output  1  transmission in progress
- done  output  1  one-cycle pulse when all repeats have finished

Behaviour:
- All outputs are registered.
- Reset values: X=0, valid=0, last=0, busy=0, done=0; state=IDLE; internal counters cleared.
- Reset overrides everything, including mid-frame; no done pulse is produced on reset.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - Outputs are all 0.
  - start=1 with rep_cnt!=0 at edge t: latch rep_cnt into reps_left, set bit index to PAT_W-1, go to SEND. First bit appears in cycle t+1 (latency 1).
  - start=1 with rep_cnt==0: go to DONE directly. valid never asserts; done pulses in cycle t+1.
- SEND:
  - Outputs: X=PATTERN[idx], valid=1, busy=1, last=1 when idx==0.
  - idx decrements each cycle.
  - At idx==0 with reps_left==1: go to DONE.
  - At idx==0 with reps_left>1: decrement reps_left and reload idx=PAT_W-1. Go to GAP if GAP>0, otherwise straight back into SEND with no bubble.
- GAP:
  - Outputs: X=0, valid=0, last=0, busy=1.
  - Lasts exactly GAP cycles, then SEND.
- DONE:
  - Outputs: done=1, busy=0, X=0, valid=0 for exactly one cycle, then IDLE.
- Total busy cycles for R repeats: R*PAT_W + (R-1)*GAP. done follows in the next cycle.
- start is ignored whenever the state is not IDLE, including the DONE cycle. A held start relaunches from IDLE one cycle after done.
- abort=1 in SEND or GAP: next state IDLE. All outputs 0 on the following cycle; no done pulse; the partial frame is discarded.
- abort in IDLE or DONE has no effect.
- If start and abort are both high in IDLE, start wins.
- reps_left never underflows. rep_cnt = 2^CNT_W-1 is legal.
- rep_cnt changes after acceptance have no effect.

Optional Feature:
- Macro: SEQ_PATTERN_TX_PARITY_EN.
- Defined: each frame is extended by one even-parity bit (XOR of PATTERN) sent after bit 0. The parity bit has valid=1, and last moves onto it. Frame length becomes PAT_W+1; busy-cycle formula uses PAT_W+1.
- Undefined: frames are exactly PAT_W bits and no parity logic exists.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> X=valid=last=busy=done=0 throughout; IDLE on release.
- Single frame: start=1, rep_cnt=1 at edge t.
  - X=1,0,1 with valid=1 in cycles t+1..t+3.
  - last=1 only in t+3; busy=1 in t+1..t+3.
  - done=1 only in t+4.
- Repeats with gap: rep_cnt=3, GAP=2.
  - X over cycles t+1..t+13 = 1,0,1,0,0,1,0,1,0,0,1,0,1.
  - valid = 1,1,1,0,0,1,1,1,0,0,1,1,1.
  - last in t+3, t+8, t+13; done in t+14.
- Ignored/zero requests:
  - start pulsed at t+2 during a rep_cnt=1 run -> no effect, single done at t+4.
  - start with rep_cnt=0 -> done next cycle, valid stays 0.
- Abort/reset mid-run: rep_cnt=3, abort=1 at edge t+6 (second frame).
  - All outputs 0 from t+7; done never pulses.
  - Repeat with rst=0 at t+6 -> identical response.
- Parity build (SEQ_PATTERN_TX_PARITY_EN, PATTERN=101, rep_cnt=2, GAP=0):
  - X = 1,0,1,0,1,0,1,0.
  - last in cycles 4 and 8; done in cycle 9.
